bcd_signed_counter: RTL and testbench



---
 rtl/ssd_pkg.sv | 15 +
 rtl/bcd_digit.sv | 33 +++
 rtl/bcd_signed_counter.sv | 143 ++++++++++++++
 tb/tb_bcd_signed_counter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared state enum and display/bound constants for the seven-segment counter
package ssd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LIMIT = 2'd3
  } state_e;

  localparam logic [3:0]  SSD_MINUS   = 4'd15;
  localparam logic [15:0] MAX_MAG     = 16'h9999;
  localparam logic [15:0] MIN_NEG_MAG = 16'h0999;

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit incrementer/decrementer with ripple carry/borrow
module bcd_digit (
  input  logic [3:0] digit_i,
  input  logic       dec_i,
  input  logic       cin_i,
  output logic [3:0] digit_o,
  output logic       cout_o
);

  // cin_i doubles as the enable: a digit only moves when everything below it wrapped
  always_comb begin
    digit_o = digit_i;
    cout_o  = 1'b0;
    if (cin_i) begin
      if (dec_i) begin
        if (digit_i == 4'd0) begin
          digit_o = 4'd9;
          cout_o  = 1'b1;
        end else begin
          digit_o = digit_i - 4'd1;
        end
      end else begin
        if (digit_i >= 4'd9) begin
          digit_o = 4'd0;
          cout_o  = 1'b1;
        end else begin
          digit_o = digit_i + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_signed_counter.sv
// rtl/bcd_signed_counter.sv - signed four-digit BCD up/down counter feeding ssd_decoder
module bcd_signed_counter
  import ssd_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_pause,
  input  logic       clr,
  input  logic       up,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       running,
  output logic       at_limit
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   mag_q, mag_d;
  logic          neg_q, neg_d;
  logic [15:0]   disp_q, disp_d;
  logic          running_q, running_d;
  logic          at_limit_q, at_limit_d;

  logic [4:0]    carry;
  logic [15:0]   mag_step;
  logic          mag_nz;
  logic          step_dec;
  logic          step_neg;
  logic          limit_hit;
  logic          step;

  // Sign-magnitude: moving toward zero decrements the magnitude, away from zero increments it
  assign mag_nz   = |mag_q;
  assign step_dec = up ? neg_q : (!neg_q && mag_nz);
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_digit u_digit (
      .digit_i (mag_q[4*i +: 4]),
      .dec_i   (step_dec),
      .cin_i   (carry[i]),
      .digit_o (mag_step[4*i +: 4]),
      .cout_o  (carry[i+1])
    );
  end

  assign step_neg  = up ? (neg_q && (|mag_step)) : (neg_q || !mag_nz);
  // A carry out of the top digit would wrap; treat it as a bound rather than rolling over
  assign limit_hit = carry[4] ||
                     (step_neg ? (mag_step == MIN_NEG_MAG) : (mag_step == MAX_MAG));
  assign step      = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    if (clr) begin
      state_d = ST_IDLE;
      presc_d = '0;
      mag_d   = '0;
      neg_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_pause) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end
        ST_RUN: begin
          if (step) begin
            presc_d = '0;
            if (!carry[4]) begin
              mag_d = mag_step;
              neg_d = step_neg;
            end
            if (limit_hit) begin
              state_d = ST_LIMIT;
            end else if (start_pause) begin
              state_d = ST_PAUSE;
            end
          end else begin
            presc_d = presc_q + PW'(1);
            if (start_pause) begin
              state_d = ST_PAUSE;
            end
          end
        end
        ST_PAUSE: begin
          if (start_pause) begin
            state_d = ST_RUN;
          end
        end
        ST_LIMIT: begin
          state_d = ST_LIMIT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    disp_d     = {(neg_d ? SSD_MINUS : mag_d[15:12]), mag_d[11:0]};
    running_d  = (state_d == ST_RUN);
    at_limit_d = (state_d == ST_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      mag_q      <= '0;
      neg_q      <= 1'b0;
      disp_q     <= '0;
      running_q  <= 1'b0;
      at_limit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      mag_q      <= mag_d;
      neg_q      <= neg_d;
      disp_q     <= disp_d;
      running_q  <= running_d;
      at_limit_q <= at_limit_d;
    end
  end

  assign d0       = disp_q[3:0];
  assign d1       = disp_q[7:4];
  assign d2       = disp_q[11:8];
  assign d3       = disp_q[15:12];
  assign running  = running_q;
  assign at_limit = at_limit_q;

endmodule

// File: tb/tb_bcd_signed_counter.sv
// tb/tb_bcd_signed_counter.sv - self-checking bench with integer reference model
module tb_bcd_signed_counter;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic start_pause;
  logic clr;
  logic up;
  logic [3:0] d0, d1, d2, d3;
  logic running, at_limit;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // model: plain signed integer value, state 0=idle 1=run 2=pause 3=limit
  int m_val = 0;
  int m_st = 0;
  int m_p = 0;

  bcd_signed_counter #(.TICK_DIV(TD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_pause (start_pause),
    .clr         (clr),
    .up          (up),
    .d0          (d0),
    .d1          (d1),
    .d2          (d2),
    .d3          (d3),
    .running     (running),
    .at_limit    (at_limit)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] exp_vec(int v, int st);
    int a;
    logic [3:0] t;
    a = (v < 0) ? -v : v;
    t = (v < 0) ? 4'd15 : 4'(a / 1000);
    return {t, 4'((a / 100) % 10), 4'((a / 10) % 10), 4'(a % 10), (st == 1), (st == 3)};
  endfunction

  function automatic logic [17:0] mk(logic [3:0] a3, logic [3:0] a2, logic [3:0] a1,
                                     logic [3:0] a0, logic r, logic l);
    return {a3, a2, a1, a0, r, l};
  endfunction

  wire [17:0] dut_vec = {d3, d2, d1, d0, running, at_limit};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_val = 0; m_st = 0; m_p = 0;
    end else if (clr) begin
      m_val = 0; m_st = 0; m_p = 0;
    end else begin
      case (m_st)
        0: if (start_pause) begin m_st = 1; m_p = 0; end
        1: begin
          if (m_p == TD - 1) begin
            m_p = 0;
            m_val = up ? m_val + 1 : m_val - 1;
            if (m_val == 9999 || m_val == -999) m_st = 3;
            else if (start_pause) m_st = 2;
          end else begin
            m_p = m_p + 1;
            if (start_pause) m_st = 2;
          end
        end
        2: if (start_pause) m_st = 1;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      checks++;
      if (dut_vec !== exp_vec(m_val, m_st)) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t dut={d3,d2,d1,d0,run,lim}=%h model=%h val=%0d",
                 $time, dut_vec, exp_vec(m_val, m_st), m_val);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_lit(string name, logic [17:0] exp);
    checks++;
    if (dut_vec !== exp) begin
      failures++;
      $display("FAIL %s dut=%h expected=%h", name, dut_vec, exp);
    end
    checks++;
    if (exp_vec(m_val, m_st) !== exp) begin
      failures++;
      $display("FAIL %s_model model=%h expected=%h", name, exp_vec(m_val, m_st), exp);
    end
  endtask

  task automatic pulse_sp();
    start_pause = 1'b1;
    tick(1);
    start_pause = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic wait_val(int v, int budget);
    int n = 0;
    while (m_val != v && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (m_val != v) begin
      failures++;
      $display("FAIL wait_val reached=%0d required=%0d", m_val, v);
    end
  endtask

  task automatic wait_lim(int budget);
    int n = 0;
    while (at_limit !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (at_limit !== 1'b1) begin
      failures++;
      $display("FAIL wait_limit at_limit=%b required=1", at_limit);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_pause = 1'b0; clr = 1'b0; up = 1'b1;
    tick(2);
    chk_lit("reset", mk(0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    chk_en = 1'b1;

    pulse_sp();
    chk_lit("run_entry", mk(0, 0, 0, 0, 1, 0));
    tick(3);
    chk_lit("hold_before_step", mk(0, 0, 0, 0, 1, 0));
    tick(1);
    chk_lit("first_step", mk(0, 0, 0, 1, 1, 0));
    tick(4);
    chk_lit("second_step", mk(0, 0, 0, 2, 1, 0));

    up = 1'b0;
    tick(4); chk_lit("down_1", mk(0, 0, 0, 1, 1, 0));
    tick(4); chk_lit("down_0", mk(0, 0, 0, 0, 1, 0));
    tick(4); chk_lit("down_neg1", mk(15, 0, 0, 1, 1, 0));
    tick(4); chk_lit("down_neg2", mk(15, 0, 0, 2, 1, 0));
    up = 1'b1;
    tick(4); chk_lit("up_neg1", mk(15, 0, 0, 1, 1, 0));
    tick(4); chk_lit("up_zero", mk(0, 0, 0, 0, 1, 0));

    pulse_clr();
    chk_lit("clr_idle", mk(0, 0, 0, 0, 0, 0));
    pulse_sp();
    wait_val(999, 5000);
    chk_lit("at_0999", mk(0, 9, 9, 9, 1, 0));
    tick(4); chk_lit("carry_1000", mk(1, 0, 0, 0, 1, 0));
    up = 1'b0;
    tick(4); chk_lit("borrow_0999", mk(0, 9, 9, 9, 1, 0));
    up = 1'b1;
    wait_lim(45000);
    chk_lit("limit_9999", mk(9, 9, 9, 9, 0, 1));
    pulse_sp();
    tick(20);
    chk_lit("limit_hold", mk(9, 9, 9, 9, 0, 1));

    pulse_clr();
    up = 1'b0;
    pulse_sp();
    wait_lim(5000);
    chk_lit("limit_neg999", mk(15, 9, 9, 9, 0, 1));
    pulse_clr();
    chk_lit("clr_from_limit", mk(0, 0, 0, 0, 0, 0));

    up = 1'b1;
    pulse_sp();
    tick(1);
    pulse_sp();
    chk_lit("paused", mk(0, 0, 0, 0, 0, 0));
    tick(10);
    chk_lit("pause_hold", mk(0, 0, 0, 0, 0, 0));
    pulse_sp();
    chk_lit("resumed", mk(0, 0, 0, 0, 1, 0));
    tick(1);
    chk_lit("resume_no_step", mk(0, 0, 0, 0, 1, 0));
    tick(1);
    chk_lit("resume_step", mk(0, 0, 0, 1, 1, 0));

    start_pause = 1'b1; clr = 1'b1;
    tick(1);
    start_pause = 1'b0; clr = 1'b0;
    chk_lit("clr_and_sp", mk(0, 0, 0, 0, 0, 0));

    pulse_sp();
    tick(9);
    chk_lit("pre_reset", mk(0, 0, 0, 2, 1, 0));
    rst_n = 1'b0;
    #1;
    chk_lit("async_reset", mk(0, 0, 0, 0, 0, 0));
    tick(1);
    rst_n = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) up = ~up;
      start_pause = ($urandom_range(0, 15) == 0);
      clr = ($urandom_range(0, 149) == 0);
      tick(1);
    end
    start_pause = 1'b0;
    clr = 1'b0;
    tick(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
